// File: rtl/dram_cmd_responder_pkg.sv
// Shared definitions for the dram_ctrl command responder: command encodings,
// responder FSM states and default device timings.
package dram_pkg;

    localparam logic [1:0] CMD_ACT   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_PRE   = 2'b11;

    localparam int DEF_T_RCD = 3;
    localparam int DEF_T_CL  = 3;
    localparam int DEF_T_WR  = 2;
    localparam int DEF_T_RP  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/dram_cmd_responder_onehot_enc.sv
// One-hot to binary encoder; index is the lowest set bit, valid means exactly
// one bit is set.
module onehot_enc #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] index,
    output logic         valid
);

    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign valid = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/dram_cmd_responder.sv
// Device-side responder for the dram_ctrl command interface: decodes selects,
// tracks per-bank open rows, models command latency and drives four-phase ack.
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_CL         = DEF_T_CL,
    parameter int T_WR         = DEF_T_WR,
    parameter int T_RP         = DEF_T_RP,
    localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int RW = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1,
    localparam int CW = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    output logic                    cmd_ack,
    output logic                    cmd_err,
    output logic                    bank_rw,
    output logic                    buf_rw,
    output logic [BW-1:0]           bank_id,
    output logic [RW-1:0]           row_id,
    output logic [CW-1:0]           col_id,
    output logic [NUM_OF_BANKS-1:0] open_banks
);

    state_t state, state_next;

    logic [1:0]              cmd_q;
    logic [NUM_OF_BANKS-1:0] bank_q;
    logic [NUM_OF_ROWS-1:0]  row_q;
    logic [NUM_OF_COLS-1:0]  col_q;
    logic [7:0]              cnt;
    logic [RW-1:0]           open_row [NUM_OF_BANKS];

    logic [BW-1:0] bank_idx;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          bank_valid, row_valid, col_valid;
    logic          is_rw, check_err;

    logic       latch_en, load_cnt, err_entry, ok_entry, ack_exit;
    logic [7:0] lat_m1;

    onehot_enc #(.N(NUM_OF_BANKS)) u_bank_enc (.vec(bank_q), .index(bank_idx), .valid(bank_valid));
    onehot_enc #(.N(NUM_OF_ROWS))  u_row_enc  (.vec(row_q),  .index(row_idx),  .valid(row_valid));
    onehot_enc #(.N(NUM_OF_COLS))  u_col_enc  (.vec(col_q),  .index(col_idx),  .valid(col_valid));

    // Selector and bank-state checks performed during LATCH.
    always_comb begin
        is_rw     = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);
        check_err = 1'b0;
        if (!bank_valid) begin
            check_err = 1'b1;
        end else if ((cmd_q == CMD_ACT) && !row_valid) begin
            check_err = 1'b1;
        end else if (is_rw && !col_valid) begin
            check_err = 1'b1;
        end else if (cmd_q == CMD_ACT) begin
            check_err = open_banks[bank_idx];
        end else begin
            check_err = !open_banks[bank_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_req) state_next = ST_LATCH;
            ST_LATCH: state_next = check_err ? ST_ACK : ST_WAIT;
            ST_WAIT:  if (cnt == 8'd0) state_next = ST_ACK;
            ST_ACK:   if (!cmd_req) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_en  = (state == ST_IDLE) && cmd_req;
        load_cnt  = (state == ST_LATCH) && !check_err;
        err_entry = (state == ST_LATCH) && check_err;
        ok_entry  = (state == ST_WAIT) && (cnt == 8'd0);
        ack_exit  = (state == ST_ACK) && !cmd_req;
        case (cmd_q)
            CMD_ACT:   lat_m1 = 8'(T_RCD - 1);
            CMD_READ:  lat_m1 = 8'(T_CL - 1);
            CMD_WRITE: lat_m1 = 8'(T_WR - 1);
            default:   lat_m1 = 8'(T_RP - 1);
        endcase
    end

    // Datapath: request capture, latency counter, bank state and ack outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= CMD_ACT;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cnt        <= '0;
            cmd_ack    <= 1'b0;
            cmd_err    <= 1'b0;
            bank_rw    <= 1'b0;
            buf_rw     <= 1'b0;
            bank_id    <= '0;
            row_id     <= '0;
            col_id     <= '0;
            open_banks <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            if (latch_en) begin
                cmd_q  <= cmd;
                bank_q <= bank_sel;
                row_q  <= row_sel;
                col_q  <= col_sel;
            end
            if (load_cnt) begin
                cnt <= lat_m1;
            end else if ((state == ST_WAIT) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
            if (err_entry) begin
                cmd_ack <= 1'b1;
                cmd_err <= 1'b1;
            end
            if (ok_entry) begin
                cmd_ack <= 1'b1;
                cmd_err <= 1'b0;
                bank_id <= bank_idx;
                case (cmd_q)
                    CMD_ACT: begin
                        open_banks[bank_idx] <= 1'b1;
                        open_row[bank_idx]   <= row_idx;
                        row_id               <= row_idx;
                    end
                    CMD_PRE: begin
                        open_banks[bank_idx] <= 1'b0;
                        row_id               <= open_row[bank_idx];
                    end
                    CMD_WRITE: begin
                        bank_rw <= 1'b1;
                        buf_rw  <= 1'b1;
                        row_id  <= open_row[bank_idx];
                        col_id  <= col_idx;
                    end
                    default: begin
                        row_id <= open_row[bank_idx];
                        col_id <= col_idx;
                    end
                endcase
            end
            if (ack_exit) begin
                cmd_ack <= 1'b0;
                cmd_err <= 1'b0;
                bank_rw <= 1'b0;
                buf_rw  <= 1'b0;
            end
        end
    end

endmodule
